// File: rtl/fsm_ordered_merge_pkg.sv
// Shared definitions for the ordered-merge controller: one-hot state codes,
// the default index width and the wrapping index increment.
package fsm_merge_pkg;

  localparam int DEF_IDX_W = 10;

  localparam logic [3:0] ST_INIT = 4'b0001;
  localparam logic [3:0] ST_WAIT = 4'b0010;
  localparam logic [3:0] ST_PUSH = 4'b0100;
  localparam logic [3:0] ST_FULL = 4'b1000;

  typedef enum logic [3:0] {
    S_INIT = ST_INIT,
    S_WAIT = ST_WAIT,
    S_PUSH = ST_PUSH,
    S_FULL = ST_FULL
  } state_t;

  // Increment modulo 2^w; callers truncate the result to their own index width.
  function automatic logic [31:0] idx_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fsm_ordered_merge_if.sv
// Channel and output-FIFO signals of the ordered-merge controller.
interface fsm_ordered_merge_if
  import fsm_merge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = DEF_IDX_W
);

    // Handshake: a channel item is offered while ch_valid[k] is high and is
    // consumed on the cycle ch_accepted[k] pulses; the source must present its
    // next item (or drop valid) by the following cycle. out_fifo_push writes the
    // item selected by ch_enable and is never issued while out_fifo_full is seen.
    logic                    out_fifo_full;
    logic                    out_fifo_clr;
    logic                    out_fifo_push;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH*IDX_W-1:0] ch_index;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_accepted;
    logic [IDX_W-1:0]        out_index;
    logic                    err_stall;
    logic                    fifo_blocked;

    modport master (
        input  out_fifo_full, ch_valid, ch_index,
        output out_fifo_clr, out_fifo_push, ch_enable, ch_accepted,
               out_index, err_stall, fifo_blocked
    );

    modport slave (
        output out_fifo_full, ch_valid, ch_index,
        input  out_fifo_clr, out_fifo_push, ch_enable, ch_accepted,
               out_index, err_stall, fifo_blocked
    );

endinterface

// File: rtl/fsm_ordered_merge_pick.sv
// Combinational arbiter: lowest channel whose tag equals the current index,
// otherwise lowest channel whose tag is the next index.
module merge_pick
  import fsm_merge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic [NUM_CH-1:0]       valid,
    input  logic [NUM_CH*IDX_W-1:0] tags,
    input  logic [IDX_W-1:0]        cur_idx,
    output logic                    found,
    output logic [NUM_CH-1:0]       sel,
    output logic                    inc
);

    logic [IDX_W-1:0]  nxt_idx;
    logic [NUM_CH-1:0] eq;
    logic [NUM_CH-1:0] nx;
    logic [NUM_CH-1:0] eq_first;
    logic [NUM_CH-1:0] nx_first;

    always_comb begin
        nxt_idx = IDX_W'(idx_inc(32'(cur_idx), IDX_W));
        eq      = '0;
        nx      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            eq[k] = valid[k] && (tags[k*IDX_W +: IDX_W] == cur_idx);
            nx[k] = valid[k] && (tags[k*IDX_W +: IDX_W] == nxt_idx);
        end
    end

    // x & -x isolates the lowest set bit, i.e. the highest-priority channel.
    assign eq_first = eq & (~eq + NUM_CH'(1));
    assign nx_first = nx & (~nx + NUM_CH'(1));

    assign found = (|eq) || (|nx);
    assign inc   = !(|eq) && (|nx);
    assign sel   = (|eq) ? eq_first : nx_first;

endmodule

// File: rtl/fsm_ordered_merge.sv
// N-channel ordered merge into the shared output FIFO: items leave strictly in
// index order, continuations of the current index ahead of the next index.
module fsm_ordered_merge
  import fsm_merge_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int STALL_W   = 8,
    parameter int STALL_MAX = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    fsm_ordered_merge_if.master bus,
    output state_t              state_dbg
);

    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  sel_q, sel_d;
    logic               inc_q, inc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic              pick_found;
    logic              pick_inc;
    logic [NUM_CH-1:0] pick_sel;
    logic              stall_hit;

    merge_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
        .valid   (bus.ch_valid),
        .tags    (bus.ch_index),
        .cur_idx (idx_q),
        .found   (pick_found),
        .sel     (pick_sel),
        .inc     (pick_inc)
    );

    // The counter saturates at the limit, so the pulse is decoded from registers.
    assign stall_hit = (STALL_MAX > 0) && (state_q == S_WAIT) && (stall_q == STALL_LIM);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= S_INIT;
            sel_q   <= '0;
            inc_q   <= 1'b0;
            idx_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            inc_q   <= inc_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        inc_d   = inc_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        case (state_q)
            S_INIT: begin
                state_d = S_WAIT;
                stall_d = '0;
            end
            S_WAIT: begin
                if (stall_hit) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    stall_d = '0;
                end else if (pick_found && !bus.out_fifo_full) begin
                    state_d = S_PUSH;
                    sel_d   = pick_sel;
                    inc_d   = pick_inc;
                    stall_d = '0;
                end else if (pick_found) begin
                    state_d = S_FULL;
                    stall_d = '0;
                end else if (!(|bus.ch_valid)) begin
                    stall_d = '0;
                end else if (!bus.out_fifo_full && (STALL_MAX > 0) && (stall_q != STALL_LIM)) begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_PUSH: begin
                state_d = S_WAIT;
                stall_d = '0;
                if (inc_q) idx_d = IDX_W'(idx_inc(32'(idx_q), IDX_W));
            end
            S_FULL: begin
                stall_d = '0;
                if (!bus.out_fifo_full) state_d = S_WAIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.out_fifo_clr  = (state_q == S_INIT);
    assign bus.out_fifo_push = (state_q == S_PUSH);
    assign bus.ch_enable     = (state_q == S_PUSH) ? sel_q : '0;
    assign bus.ch_accepted   = (state_q == S_PUSH) ? sel_q : '0;
    assign bus.out_index     = idx_q;
    assign bus.err_stall     = stall_hit;
    assign bus.fifo_blocked  = (state_q == S_FULL);
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_fsm_ordered_merge.sv
// Bench for fsm_ordered_merge: random per-channel item lists ordered by a
// list-level reference model, plus directed full, watchdog and flush cases.
module tb_fsm_ordered_merge;
    import fsm_merge_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int IDX_W     = 4;
    localparam int STALL_W   = 8;
    localparam int STALL_MAX = 8;
    localparam int MAXL      = 16;

    typedef struct packed {
        logic [1:0]       ch;
        logic [IDX_W-1:0] tag;
        logic [IDX_W-1:0] post;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   flush;
    state_t state_dbg;

    fsm_ordered_merge_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus ();

    fsm_ordered_merge #(
        .NUM_CH(NUM_CH), .IDX_W(IDX_W), .STALL_W(STALL_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    exp_t             exp_q[$];
    exp_t             mon_e;
    int               tests_run = 0;
    int               fails = 0;
    int               err_cnt = 0;
    int               clr_cnt = 0;
    int               push_cnt = 0;
    logic             idx_pend = 1'b0;
    logic [IDX_W-1:0] idx_want;

    int               src_len[NUM_CH];
    int               src_pos[NUM_CH];
    logic [IDX_W-1:0] src_tag[NUM_CH][MAXL];
    bit               rand_full = 1'b0;
    logic [IDX_W-1:0] model_idx;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (idx_pend) begin
            check("post_push_index", bus.out_index, idx_want);
            idx_pend = 1'b0;
        end
        if (bus.err_stall)    err_cnt++;
        if (bus.out_fifo_clr) clr_cnt++;
        if (bus.out_fifo_push) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("push_ch_enable", bus.ch_enable, 1 << mon_e.ch);
                check("push_ch_accepted", bus.ch_accepted, 1 << mon_e.ch);
                idx_want = mon_e.post;
                idx_pend = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_srcs();
        for (int k = 0; k < NUM_CH; k++) begin
            if (src_pos[k] < src_len[k]) begin
                bus.ch_valid[k] = 1'b1;
                bus.ch_index[k*IDX_W +: IDX_W] = src_tag[k][src_pos[k]];
            end else begin
                bus.ch_valid[k] = 1'b0;
                bus.ch_index[k*IDX_W +: IDX_W] = '0;
            end
        end
    endtask

    // Inputs change 1 time unit after the falling edge, after the monitor sampled.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++)
            if (bus.ch_accepted[k] && src_pos[k] < src_len[k]) src_pos[k]++;
        drive_srcs();
        if (rand_full) bus.out_fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NUM_CH; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        drive_srcs();
    endtask

    task automatic set_one(input int ch, input int tag);
        clear_srcs();
        src_tag[ch][0] = IDX_W'(tag);
        src_len[ch]    = 1;
        drive_srcs();
    endtask

    task automatic add_item(input int ch, input int tag);
        src_tag[ch][src_len[ch]] = IDX_W'(tag);
        src_len[ch]++;
    endtask

    // Reference: repeatedly take the lowest channel whose head equals the index,
    // else the lowest whose head is index+1; the index becomes the served tag.
    task automatic model_and_run(input string name);
        int               pos[NUM_CH];
        int               total;
        int               pick;
        int               cyc;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] nidx;
        exp_t             e;
        total = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos[k] = 0;
            total += src_len[k];
        end
        idx = model_idx;
        for (int n = 0; n < total; n++) begin
            nidx = idx + 1'b1;
            pick = -1;
            for (int k = NUM_CH - 1; k >= 0; k--)
                if (pos[k] < src_len[k] && src_tag[k][pos[k]] == idx) pick = k;
            if (pick < 0)
                for (int k = NUM_CH - 1; k >= 0; k--)
                    if (pos[k] < src_len[k] && src_tag[k][pos[k]] == nidx) pick = k;
            if (pick < 0) break;
            e.ch   = 2'(pick);
            e.tag  = src_tag[pick][pos[pick]];
            e.post = e.tag;
            exp_q.push_back(e);
            idx = e.tag;
            pos[pick]++;
        end
        model_idx = idx;
        drive_srcs();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            tick();
            cyc++;
        end
        rand_full = 1'b0;
        bus.out_fifo_full = 1'b0;
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
        check({name, "_index"}, bus.out_index, model_idx);
        clear_srcs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        check("reset_clr", bus.out_fifo_clr, 1);
        check("reset_push", bus.out_fifo_push, 0);
        check("reset_index", bus.out_index, 0);
        check("reset_state", state_dbg, ST_INIT);
        reset = 1'b0;
        model_idx = '0;
        repeat (3) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0, c0, p0, blk, n;
        logic seen;
        reset = 1'b1;
        flush = 1'b0;
        bus.out_fifo_full = 1'b0;
        bus.ch_valid = '0;
        bus.ch_index = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end

        do_reset();
        c0 = clr_cnt;
        tick();
        check("clr_after_release", clr_cnt - c0, 0);

        // ch0 tags 0,0,1: three pushes, index 0,0,1
        clear_srcs();
        add_item(0, 0); add_item(0, 0); add_item(0, 1);
        model_and_run("ch0_seq");

        // EQ on ch2 beats NX on ch0
        clear_srcs();
        add_item(2, model_idx); add_item(0, model_idx + 1);
        model_and_run("eq_beats_nx");

        // same tag on ch1 and ch3: ch1 first
        clear_srcs();
        add_item(3, model_idx); add_item(1, model_idx);
        model_and_run("low_ch_first");

        // random lists; spans accumulate past 2^IDX_W so the index wraps
        e0 = err_cnt;
        for (int s = 0; s < 14; s++) begin
            int span;
            clear_srcs();
            span = $urandom_range(2, 5);
            for (int d = 0; d < span; d++) begin
                int cnt;
                cnt = $urandom_range(1, 3);
                for (int j = 0; j < cnt; j++)
                    add_item($urandom_range(0, NUM_CH - 1), int'(model_idx) + d);
            end
            rand_full = (s % 2 == 1);
            model_and_run("random");
        end
        check("random_no_err_stall", err_cnt - e0, 0);

        // FIFO full for 10 cycles with a candidate waiting
        e0 = err_cnt;
        p0 = push_cnt;
        bus.out_fifo_full = 1'b1;
        set_one(1, model_idx);
        exp_q.push_back('{ch: 2'd1, tag: model_idx, post: model_idx});
        blk = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            blk += int'(bus.fifo_blocked);
        end
        check("full_blocked_cycles", blk, 10);
        check("full_no_push", push_cnt - p0, 0);
        check("full_no_err", err_cnt - e0, 0);
        bus.out_fifo_full = 1'b0;
        tick();
        check("full_release_wait", bus.out_fifo_push, 0);
        tick();
        check("full_release_push", bus.out_fifo_push, 1);
        tick();
        tick();
        check("full_drained", exp_q.size(), 0);
        clear_srcs();

        // watchdog: unmatched tag 5 at index 0
        do_reset();
        e0 = err_cnt;
        set_one(0, 5);
        n = 0;
        while (err_cnt == e0 && n < 30) begin
            tick();
            n++;
        end
        check("stall_cycles", n, STALL_MAX);
        clear_srcs();
        tick();
        check("stall_init_clr", bus.out_fifo_clr, 1);
        check("stall_init_index", bus.out_index, 0);
        check("stall_pulse_width", err_cnt - e0, 1);
        model_idx = '0;
        repeat (3) tick();

        // flush mid-stall
        e0 = err_cnt;
        set_one(0, 5);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_srcs();
        check("flush_state_init", state_dbg, ST_INIT);
        check("flush_clr", bus.out_fifo_clr, 1);
        repeat (12) tick();
        check("flush_no_err", err_cnt - e0, 0);

        // flush during a PUSH with increment: push completes, increment lost
        set_one(0, 1);
        exp_q.push_back('{ch: 2'd0, tag: 4'd1, post: 4'd0});
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            tick();
            n++;
            seen = bus.out_fifo_push;
        end
        check("flush_push_seen", seen, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_push_index", bus.out_index, 0);
        check("flush_push_drained", exp_q.size(), 0);
        model_idx = '0;
        repeat (3) tick();

        // normal operation resumes after flush
        clear_srcs();
        add_item(0, 0); add_item(1, 1); add_item(2, 1); add_item(0, 2);
        model_and_run("after_flush");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fsm_ordered_merge.md
Name: fsm_ordered_merge

Overview:
N-channel ordered-merge controller for the serialiser output path. Each channel presents an item tagged with a sequence index. The block pushes items into the shared output FIFO strictly in index order, and continuation items of the current index go before the first item of the next index. It generalises the two-channel varint/raw merge FSM: channel count and index width are parametrised, full handling is non-fatal, a stall watchdog is added, and a soft flush is available.

Parameters:
NUM_CH, 2, number of input channels (2..16); channel 0 has highest priority.
IDX_W, 10, width of sequence index; wraps modulo 2^IDX_W.
STALL_W, 8, width of stall counter.
STALL_MAX, 200, WAIT cycles with valid-but-unmatched data before error; 0 disables the watchdog.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  soft restart pulse; same effect as reset on the next edge
out_fifo_full  in  1  output FIFO full
out_fifo_clr  out  1  output FIFO clear
out_fifo_push  out  1  output FIFO push strobe
ch_valid  in  NUM_CH  per-channel item valid
ch_index  in  NUM_CH*IDX_W  per-channel item tag; channel k occupies bits [k*IDX_W +: IDX_W]
ch_enable  out  NUM_CH  one-hot data-mux select into the FIFO
ch_accepted  out  NUM_CH  one-hot accept pulse to the source
out_index  out  IDX_W  current sequence index
err_stall  out  1  one-cycle pulse when the watchdog fires
fifo_blocked  out  1  high while in state FULL

Behaviour:
- States: INIT, WAIT, PUSH, FULL. One-hot encoding. Outputs decode from state and registered select only; no input-to-output combinational path.
- reset or flush at an edge: state <= INIT, out_index <= 0, stall counter <= 0, select <= 0. reset has priority over flush.
- INIT: out_fifo_clr=1 for exactly one cycle, then WAIT. All other outputs are 0.
- Classes per channel k:
  - EQ[k] = ch_valid[k] && tag==out_index.
  - NX[k] = ch_valid[k] && tag==out_index+1 (mod 2^IDX_W).
- Candidate: lowest k with EQ[k]; if none, lowest k with NX[k]. inc flag = candidate came from NX.
- WAIT:
  - Candidate and !out_fifo_full: latch sel=k and inc, go to PUSH.
  - Candidate and full: go to FULL; no latch.
  - Otherwise stay in WAIT.
- PUSH, for exactly one cycle:
  - out_fifo_push=1, ch_enable[sel]=1, ch_accepted[sel]=1.
  - If inc, out_index <= out_index+1 with wrap.
  - Next state is WAIT.
  - Throughput is 1 item per 2 cycles. Sources must update valid/tag by the cycle after ch_accepted.
- FULL:
  - fifo_blocked=1; no push.
  - When out_fifo_full deasserts, go to WAIT and re-arbitrate. No error path; a vanished candidate is legal.
- Watchdog, active only when STALL_MAX>0:
  - Counter increments in WAIT when any ch_valid=1, no candidate, and not full.
  - Counter clears on any push, in FULL, or when no channel is valid.
  - On reaching STALL_MAX: err_stall=1 for one cycle, and next state INIT (FIFO cleared, index reset).
- Simultaneous EQ and NX on different channels: EQ wins. The NX item is served on a later WAIT.
- A single channel never sees EQ and NX simultaneously; tags are compared to equal values only.
- Widths: all index compares are IDX_W bits; +1 wraps naturally. Counter saturates at STALL_MAX.
- Reset or flush during PUSH: the push in that cycle still completes. The state then goes to INIT and the increment is discarded.

Decomposition:
- Shared package fsm_merge_pkg holds: state encoding constants (ST_INIT, ST_WAIT, ST_PUSH, ST_FULL), default IDX_W, and a function for modulo-increment of the index.
- One sub-module, merge_pick: combinational, parametrised on NUM_CH/IDX_W. Takes valids, tags and out_index; returns found, one-hot sel and inc, using two-level find-first priority.

Test Plan:
1. Reset released; ch0 tags 0,0,1 presented after each accept. Expect: out_fifo_clr high 1 cycle; 3 pushes spaced 2 cycles; out_index 0,0,1 after each push; ch_accepted[0] pulses align with pushes.
2. NUM_CH=4, out_index=3; ch2 tag 3 and ch0 tag 4 both valid. Expect: ch2 pushed first with out_index unchanged; then ch0 pushed and out_index becomes 4.
3. ch1 and ch3 both tag 3 with out_index=3. Expect: ch1 pushed first, ch3 on the next PUSH.
4. Candidate valid with out_fifo_full=1 for 10 cycles. Expect: fifo_blocked=1, no push, no err_stall. After full drops: push occurs 2 cycles later.
5. IDX_W=4, out_index=15, ch0 tag 0. Expect: push with inc; out_index wraps to 0.
6. STALL_MAX=8; ch0 valid with tag 5 while out_index=0. Expect: err_stall pulse after 8 WAIT cycles, then INIT with out_fifo_clr=1 and out_index=0. Repeat with flush mid-stall: INIT immediately, no err_stall.
